// File: rtl/plic_gateway.sv
// PLIC interrupt gateway.
// Each source has a synchroniser and a three-state FSM: IDLE, PEND and SERVICE.
// In edge mode a saturating counter holds extra edges that arrive while the
// source is already pending or in service.
module plic_gateway #(
   parameter int SRC_NUM = 8,
   parameter int CNT_W   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SRC_NUM-1:0] irq_src,
   input  logic [SRC_NUM-1:0] edge_mode,
   input  logic               claim_vld,
   input  logic [7:0]         claim_id,
   input  logic               complete_vld,
   input  logic [7:0]         complete_id,
   output logic [SRC_NUM-1:0] pending,
   output logic [SRC_NUM-1:0] in_service
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PEND    = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SRC_NUM-1:0] s1;
   logic [SRC_NUM-1:0] s2;
   logic [SRC_NUM-1:0] s3;
   logic [SRC_NUM-1:0] req_lvl;
   logic [SRC_NUM-1:0] req_edge;

   // Two-flop synchroniser for the raw lines, plus a history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= irq_src;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign req_lvl  = s2;
   assign req_edge = s2 & ~s3;

   for (genvar g = 0; g < SRC_NUM; g++) begin : g_src
      localparam logic [7:0] SRC_ID = 8'(g + 1);

      state_t           state;
      state_t           state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             req;
      logic             claim_hit;
      logic             complete_hit;
      logic             inc;
      logic             dec;

      assign req          = edge_mode[g] ? req_edge[g] : req_lvl[g];
      assign claim_hit    = claim_vld && (claim_id == SRC_ID);
      assign complete_hit = complete_vld && (complete_id == SRC_ID);

      // State and edge-count registers for this source.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
         end
      end

      // Next-state and counter logic. A claim or complete acts only when its
      // ID matches this source and the source is in the matching state, so an
      // invalid ID or a command for the wrong state leaves the source unchanged.
      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         inc       = 1'b0;
         dec       = 1'b0;
         case (state)
            IDLE: begin
               if (req) state_nxt = PEND;
            end
            PEND: begin
               inc = req_edge[g];
               if (claim_hit) state_nxt = SERVICE;
            end
            SERVICE: begin
               if (complete_hit) begin
                  if (edge_mode[g] && (cnt != '0)) begin
                     state_nxt = PEND;
                     dec       = 1'b1;
                     inc       = req_edge[g];
                  end else if (edge_mode[g] && req_edge[g]) begin
                     // This edge re-pends the source directly, so it is not counted.
                     state_nxt = PEND;
                  end else if (!edge_mode[g] && req_lvl[g]) begin
                     state_nxt = PEND;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  inc = req_edge[g];
               end
            end
            default: state_nxt = IDLE;
         endcase

         if (!edge_mode[g]) begin
            cnt_nxt = '0;
         end else if (inc && !dec) begin
            if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
         end else if (dec && !inc) begin
            cnt_nxt = cnt - 1'b1;
         end
      end

      assign pending[g]    = (state == PEND);
      assign in_service[g] = (state == SERVICE);
   end

endmodule
